// File: rtl/lu_pkg.sv
// Shared definitions for the 2-level logic unit and its sweep driver.
//   - LU_OP_* : operation codes carried on {s2, s1}
//   - lu_state_t : sweep driver FSM state encoding
//   - LU_GOLDEN : expected results word for a fully correct unit, bit i = vector i
//   - lu_apply_op() : golden function of one operation on (x, y)
package lu_pkg;

  localparam logic [1:0] LU_OP_NAND = 2'b00;
  localparam logic [1:0] LU_OP_AND  = 2'b01;
  localparam logic [1:0] LU_OP_NOR  = 2'b10;
  localparam logic [1:0] LU_OP_OR   = 2'b11;

  localparam int unsigned LU_NUM_VECTORS = 16;
  localparam logic [15:0] LU_GOLDEN      = 16'hE187;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } lu_state_t;

  // Result of the selected operation on (x, y). op = {s2, s1}.
  function automatic logic lu_apply_op(input logic [1:0] op, input logic x, input logic y);
    logic r;
    case (op)
      LU_OP_NAND: r = ~(x & y);
      LU_OP_AND:  r = x & y;
      LU_OP_NOR:  r = ~(x | y);
      default:    r = x | y;  // LU_OP_OR
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lu_ref_model.sv
// Combinational golden model of the logic unit.
// Ports:
//   s2, s1 : operation select ({s2,s1}: 00 NAND, 01 AND, 10 NOR, 11 OR)
//   x, y   : operands
//   exp_z  : expected result bit
module lu_ref_model (
  input  logic s2,
  input  logic s1,
  input  logic x,
  input  logic y,
  output logic exp_z
);
  import lu_pkg::*;

  always_comb begin
    exp_z = lu_apply_op({s2, s1}, x, y);
  end

endmodule

// File: rtl/lu_sweep_driver.sv
// Initiator/checker for the 2-level logic unit. On start it walks all 16
// {s2,s1,x,y} vectors, holds each for SETTLE_CYCLES wait cycles plus one
// sample cycle, captures lu_z on the edge ending the sample cycle and
// compares it against the golden function.
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   start               : sweep request, honoured only in IDLE or DONE
//   lu_x/lu_y/lu_s1/lu_s2 : vector driven to the unit, = idx register
//   lu_z                : result bit returned by the unit
//   busy                : sweep in progress (WAIT or SAMPLE)
//   done                : sweep complete, held until next start or reset
//   results             : captured lu_z, bit i = vector i
//   err_mask            : per-vector mismatch flags
//   err                 : sticky OR of mismatches seen in the current sweep
module lu_sweep_driver #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        lu_x,
  output logic        lu_y,
  output logic        lu_s1,
  output logic        lu_s2,
  input  logic        lu_z,
  output logic        busy,
  output logic        done,
  output logic [15:0] results,
  output logic [15:0] err_mask,
  output logic        err
);
  import lu_pkg::*;

  // With no settle interval the FSM bypasses WAIT and samples every cycle.
  localparam bit          NO_SETTLE       = (SETTLE_CYCLES == 0);
  localparam int unsigned SETTLE_LAST_INT = NO_SETTLE ? 0 : SETTLE_CYCLES - 1;
  localparam logic [3:0]  SETTLE_LAST     = SETTLE_LAST_INT[3:0];

  lu_state_t  state_reg, state_next;
  logic [3:0] idx_reg;
  logic [3:0] cnt_reg;
  logic       err_reg;

  logic sweep_start;  // start accepted: clear captured data, rewind idx/cnt
  logic cnt_inc;
  logic cnt_clear;
  logic capture;      // this cycle's edge captures lu_z for idx_reg
  logic idx_inc;

  logic exp_z;
  logic mismatch;

  // The vector is the index register itself, so the unit sees it with no lag.
  assign {lu_s2, lu_s1, lu_x, lu_y} = idx_reg;

  lu_ref_model u_ref (
    .s2    (idx_reg[3]),
    .s1    (idx_reg[2]),
    .x     (idx_reg[1]),
    .y     (idx_reg[0]),
    .exp_z (exp_z)
  );

  // X on lu_z propagates into the captured data unchanged.
  assign mismatch = (lu_z != exp_z);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_next  = state_reg;
    sweep_start = 1'b0;
    cnt_inc     = 1'b0;
    cnt_clear   = 1'b0;
    capture     = 1'b0;
    idx_inc     = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sweep_start = 1'b1;
          state_next  = NO_SETTLE ? ST_SAMPLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_reg == SETTLE_LAST) begin
          cnt_clear  = 1'b1;
          state_next = ST_SAMPLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_SAMPLE: begin
        capture = 1'b1;
        if (idx_reg == 4'd15) begin
          state_next = ST_DONE;
        end else begin
          idx_inc    = 1'b1;
          state_next = NO_SETTLE ? ST_SAMPLE : ST_WAIT;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Vector index and settle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_reg <= 4'd0;
      cnt_reg <= 4'd0;
    end else begin
      if (sweep_start) begin
        idx_reg <= 4'd0;
      end else if (idx_inc) begin
        idx_reg <= idx_reg + 4'd1;
      end

      if (sweep_start || cnt_clear) begin
        cnt_reg <= 4'd0;
      end else if (cnt_inc) begin
        cnt_reg <= cnt_reg + 4'd1;
      end
    end
  end

  // Sticky error: updated on every capture so it rises mid-sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (sweep_start) begin
      err_reg <= 1'b0;
    end else if (capture) begin
      err_reg <= err_reg | mismatch;
    end
  end

  // One capture cell per vector; only the cell addressed by idx_reg loads.
  generate
    for (genvar gi = 0; gi < LU_NUM_VECTORS; gi++) begin : g_cap
      logic res_bit_reg;
      logic err_bit_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          res_bit_reg <= 1'b0;
          err_bit_reg <= 1'b0;
        end else if (sweep_start) begin
          res_bit_reg <= 1'b0;
          err_bit_reg <= 1'b0;
        end else if (capture && (idx_reg == 4'(gi))) begin
          res_bit_reg <= lu_z;
          err_bit_reg <= mismatch;
        end
      end

      assign results[gi]  = res_bit_reg;
      assign err_mask[gi] = err_bit_reg;
    end
  endgenerate

  assign err  = err_reg;
  assign busy = (state_reg == ST_WAIT) || (state_reg == ST_SAMPLE);
  assign done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_lu_sweep_driver.sv
// Self-checking bench for lu_sweep_driver: one instance with SETTLE_CYCLES=1
// attached to a configurable logic-unit model, one with SETTLE_CYCLES=0
// attached to a correct unit.
module tb_lu_sweep_driver;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance with SETTLE_CYCLES = 1 ----------------
  logic        start1;
  logic        x1, y1, s1_1, s2_1, z1;
  logic        busy1, done1, err1;
  logic [15:0] results1, mask1;
  int          mode1;        // 0 correct, 1 stuck-0, 2 stuck-1, 3 s1 inverted, 4 flip pattern
  logic [15:0] flip1;

  lu_sweep_driver #(.SETTLE_CYCLES(1)) dut_s1 (
    .clk      (clk),
    .reset    (reset),
    .start    (start1),
    .lu_x     (x1),
    .lu_y     (y1),
    .lu_s1    (s1_1),
    .lu_s2    (s2_1),
    .lu_z     (z1),
    .busy     (busy1),
    .done     (done1),
    .results  (results1),
    .err_mask (mask1),
    .err      (err1)
  );

  // ---------------- instance with SETTLE_CYCLES = 0 ----------------
  logic        start0;
  logic        x0, y0, s1_0, s2_0, z0;
  logic        busy0, done0, err0;
  logic [15:0] results0, mask0;

  lu_sweep_driver #(.SETTLE_CYCLES(0)) dut_s0 (
    .clk      (clk),
    .reset    (reset),
    .start    (start0),
    .lu_x     (x0),
    .lu_y     (y0),
    .lu_s1    (s1_0),
    .lu_s2    (s2_0),
    .lu_z     (z0),
    .busy     (busy0),
    .done     (done0),
    .results  (results0),
    .err_mask (mask0),
    .err      (err0)
  );

  // Behavioural truth: operation chosen by {s2,s1}, evaluated arithmetically.
  function automatic logic gold(input logic [3:0] v);
    int a, b, prod, sum;
    a    = int'(v[1]);
    b    = int'(v[0]);
    prod = a * b;
    sum  = a + b;
    case (v[3:2])
      2'd0:    return (prod == 0);  // NAND
      2'd1:    return (prod == 1);  // AND
      2'd2:    return (sum == 0);   // NOR
      default: return (sum > 0);    // OR
    endcase
  endfunction

  function automatic logic [15:0] gold_word();
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[i] = gold(4'(i));
    return w;
  endfunction

  // Logic unit under various fault models.
  function automatic logic unit_z(input int mode, input logic [15:0] flip, input logic [3:0] v);
    case (mode)
      0:       return gold(v);
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return gold({v[3], ~v[2], v[1:0]});
      default: return gold(v) ^ flip[v];
    endcase
  endfunction

  assign z1 = unit_z(mode1, flip1, {s2_1, s1_1, x1, y1});
  assign z0 = unit_z(0, 16'h0000, {s2_0, s1_0, x0, y0});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct {
    int          mode;
    logic [15:0] flip;
    logic [15:0] exp_results;
    logic [15:0] exp_mask;
    logic        exp_err;
  } vec_t;

  vec_t tbl[8];

  // Full sweep on the SETTLE_CYCLES=1 instance, optionally firing stray
  // start pulses while busy (they must be ignored).
  task automatic sweep1(input int n, input vec_t v, input bit stray);
    int cycles;
    mode1 = v.mode;
    flip1 = v.flip;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    chk($sformatf("t%0d_busy", n), 32'(busy1), 32'd1);
    cycles = 0;
    while (!done1 && cycles < 100) begin
      start1 = stray && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      cycles++;
    end
    start1 = 1'b0;
    chk($sformatf("t%0d_latency", n), 32'(cycles), 32'd32);
    chk($sformatf("t%0d_results", n), 32'(results1), 32'(v.exp_results));
    chk($sformatf("t%0d_err_mask", n), 32'(mask1), 32'(v.exp_mask));
    chk($sformatf("t%0d_err", n), 32'(err1), 32'(v.exp_err));
    $display("sweep %0d mode=%0d flip=%04h results=%04h err_mask=%04h err=%0d cycles=%0d",
             n, v.mode, v.flip, results1, mask1, err1, cycles);
  endtask

  // Sweep on the SETTLE_CYCLES=0 instance with stray starts at fixed cycles.
  task automatic sweep0(input string tag);
    int cycles;
    cycles = 0;
    while (!done0 && cycles < 60) begin
      start0 = (cycles == 3) || (cycles == 7) || (cycles == 11);
      @(negedge clk);
      cycles++;
    end
    start0 = 1'b0;
    chk({tag, "_latency"}, 32'(cycles), 32'd16);
    chk({tag, "_results"}, 32'(results0), 32'hE187);
    chk({tag, "_err_mask"}, 32'(mask0), 32'h0);
    chk({tag, "_err"}, 32'(err0), 32'h0);
    $display("sweep0 %s results=%04h err_mask=%04h cycles=%0d", tag, results0, mask0, cycles);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] g;
    int          cyc;
    vec_t        v;

    reset  = 1'b1;
    start1 = 1'b0;
    start0 = 1'b0;
    mode1  = 0;
    flip1  = 16'h0;

    g = gold_word();
    tbl[0] = '{0, 16'h0000, 16'hE187, 16'h0000, 1'b0};
    tbl[1] = '{1, 16'h0000, 16'h0000, 16'hE187, 1'b1};
    tbl[2] = '{2, 16'h0000, 16'hFFFF, 16'h1E78, 1'b1};
    tbl[3] = '{3, 16'h0000, 16'h1E78, 16'hFFFF, 1'b1};
    for (int i = 4; i < 8; i++) begin
      logic [15:0] f;
      f = 16'($urandom);
      if (i == 4) f = 16'h8000;  // only the last vector wrong
      tbl[i] = '{4, f, g ^ f, f, (f != 16'h0)};
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_results", 32'(results1), 32'd0);
    chk("rst_err_mask", 32'(mask1), 32'd0);
    chk("rst_err", 32'(err1), 32'd0);
    chk("rst_vector", 32'({s2_1, s1_1, x1, y1}), 32'd0);
    chk("rst_done0", 32'(done0), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy1), 32'd0);

    // Table-driven full sweeps
    for (int i = 0; i < 8; i++) begin
      sweep1(i, tbl[i], i >= 4);
      chk($sformatf("t%0d_done_hold", i), 32'(done1), 32'd1);
    end

    // Restart from DONE with a stuck-0 unit: err must clear, then rise on
    // the capture of vector 0 (edge 2 after the start edge).
    mode1 = 1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    chk("s0_done_drop", 32'(done1), 32'd0);
    chk("s0_err_clear", 32'(err1), 32'd0);
    chk("s0_results_clear", 32'(results1), 32'd0);
    @(negedge clk);
    chk("s0_err_pre", 32'(err1), 32'd0);
    @(negedge clk);
    chk("s0_err_rise", 32'(err1), 32'd1);
    chk("s0_mask_first", 32'(mask1), 32'h0001);
    cyc = 0;
    while (!done1 && cyc < 100) begin @(negedge clk); cyc++; end
    chk("s0_final_mask", 32'(mask1), 32'hE187);
    $display("sweep stuck0 err-timing results=%04h err_mask=%04h", results1, mask1);

    // Reset mid-sweep at idx 7 with a stuck-1 unit
    mode1 = 2;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    cyc = 0;
    while ({s2_1, s1_1, x1, y1} != 4'd7 && cyc < 100) begin @(negedge clk); cyc++; end
    chk("mid_reached_idx7", 32'({s2_1, s1_1, x1, y1}), 32'd7);
    chk("mid_partial_results", 32'(results1), 32'h007F);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_results", 32'(results1), 32'd0);
    chk("mid_rst_err_mask", 32'(mask1), 32'd0);
    chk("mid_rst_err", 32'(err1), 32'd0);
    chk("mid_rst_busy", 32'(busy1), 32'd0);
    chk("mid_rst_done", 32'(done1), 32'd0);
    chk("mid_rst_vector", 32'({s2_1, s1_1, x1, y1}), 32'd0);
    $display("reset mid-sweep results=%04h busy=%0d", results1, busy1);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("mid_idle_busy", 32'(busy1), 32'd0);
    v = tbl[0];
    sweep1(100, v, 1'b0);

    // SETTLE_CYCLES = 0: latency 16, stray starts ignored, restart from DONE
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    chk("z_busy", 32'(busy0), 32'd1);
    sweep0("z_first");
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    chk("z_restart_done_drop", 32'(done0), 32'd0);
    chk("z_restart_results_clear", 32'(results0), 32'd0);
    chk("z_restart_busy", 32'(busy0), 32'd1);
    sweep0("z_second");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lu_sweep_driver.md
Name: lu_sweep_driver

Overview:
- Initiator/checker side of the 2-level logic unit (AND/NAND/OR/NOR behind three 2:1 muxes).
- The logic unit only consumes operands x, y and selects s1, s2, and returns one result bit z. This block drives that interface instead of receiving it.
- On a start request it sweeps all 16 {s2,s1,x,y} combinations, holds each vector for a settle interval, and samples z.
- It records each returned bit, compares it against the golden function, and reports per-vector error bits and a sticky error flag with a done handshake.

Parameters:
- SETTLE_CYCLES, 1, number of wait cycles between applying a vector and sampling lu_z; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  sweep request, sampled only in IDLE or DONE.
- lu_x  output  1  operand x to the logic unit.
- lu_y  output  1  operand y to the logic unit.
- lu_s1  output  1  inner select: 1 = AND/OR, 0 = NAND/NOR.
- lu_s2  output  1  outer select: 0 = AND/NAND group, 1 = OR/NOR group.
- lu_z  input  1  result bit returned by the logic unit.
- busy  output  1  high while the sweep is in progress (WAIT or SAMPLE).
- done  output  1  high in DONE; held until the next start or reset.
- results  output  16  results[i] = lu_z sampled for vector i.
- err_mask  output  16  err_mask[i] = 1 when vector i mismatched.
- err  output  1  OR of err_mask; sticky until the next start.

Behaviour:
- Vector index idx is a 4-bit register. {lu_s2, lu_s1, lu_x, lu_y} = idx at all times, driven directly from the register with no extra latency.
- Op encoding {s2,s1}:
  - 00 = NAND
  - 01 = AND
  - 10 = NOR
  - 11 = OR
- Golden function exp(idx): apply the op to (x,y). For a correct unit, results = 16'hE187.
- Reset (asynchronous, any state, including mid-sweep):
  - state = IDLE, idx = 0, cnt = 0.
  - busy = 0, done = 0, results = 0, err_mask = 0, err = 0.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE, start = 1:
  - clear results, err_mask and err.
  - idx = 0, cnt = 0.
  - next state is WAIT, or SAMPLE if SETTLE_CYCLES = 0.
- WAIT:
  - cnt increments each cycle.
  - when cnt = SETTLE_CYCLES-1, clear cnt and go to SAMPLE.
- SAMPLE (exactly one cycle; capture happens on the clock edge ending it):
  - results[idx] <= lu_z.
  - err_mask[idx] <= (lu_z != exp(idx)).
  - err <= err | mismatch.
  - if idx = 15, go to DONE; otherwise idx <= idx+1 and return to WAIT (or stay in SAMPLE when SETTLE_CYCLES = 0).
- DONE:
  - done = 1; results, err_mask and err held stable; idx remains 15.
  - start = 1 behaves as in IDLE: clear everything and restart the sweep; done drops on the next cycle.
- start while busy: ignored, with no effect on idx, cnt or the captured data.
- Latency: done first goes high 16*(SETTLE_CYCLES+1) cycles after the start edge (32 at the default).
- Per vector: lu_* is stable for SETTLE_CYCLES+1 cycles before the capture edge.
- err reflects mismatches incrementally during the sweep, not only at completion.
- X on lu_z: it is captured as-is; no special handling.

Decomposition:
- Shared package lu_pkg:
  - op-code constants LU_OP_NAND = 2'b00, LU_OP_AND = 2'b01, LU_OP_NOR = 2'b10, LU_OP_OR = 2'b11.
  - state encoding constants.
  - LU_GOLDEN = 16'hE187.
- One natural sub-module, lu_ref_model: combinational exp = f(s2, s1, x, y), reusable by other benches.
- The FSM, counter and capture registers live in lu_sweep_driver.

Test Plan:
- Correct gate-level logic unit attached, SETTLE_CYCLES = 1, start pulse → done high 32 cycles later, results = 16'hE187, err_mask = 0, err = 0.
- lu_z tied to 0 → results = 16'h0000, err_mask = 16'hE187, err = 1; err first rises on the capture of idx 0.
- lu_z tied to 1 → results = 16'hFFFF, err_mask = 16'h1E78, err = 1.
- Unit with s1 inverted (AND↔NAND, OR↔NOR swapped) → results = 16'h1E78, err_mask = 16'hFFFF.
- Reset asserted mid-sweep at idx = 7 → all outputs 0 immediately (asynchronous), state IDLE. A subsequent start gives a full clean sweep with results = 16'hE187.
- Timing and handshake, SETTLE_CYCLES = 0:
  - done after exactly 16 cycles.
  - start pulses during busy are ignored.
  - start in DONE restarts: done drops, results clear to 0, and the second sweep again yields 16'hE187.
